// File: rtl/pit_bus_master_if.sv
// Command/response handshake and 8253 bus pins of pit_bus_master.
// master = sequencer side, slave = host/bus-model side.
interface pit_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [1:0]  cmd_chan;
    logic [1:0]  cmd_rw;
    logic [2:0]  cmd_mode;
    logic [15:0] cmd_count;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_data;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic        a1;
    logic        a0;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;

    modport master (
        input  cmd_valid, cmd_op, cmd_chan, cmd_rw, cmd_mode, cmd_count, d_in,
        output cmd_ready, rsp_valid, rsp_err, rsp_data,
        output cs_n, rd_n, wr_n, a1, a0, d_out, d_oe
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_chan, cmd_rw, cmd_mode, cmd_count, d_in,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data,
        input  cs_n, rd_n, wr_n, a1, a0, d_out, d_oe
    );
endinterface

// File: rtl/pit_bus_master.sv
// Expands program / latch-and-read commands into timed 8253 bus cycles.
// Optional `PIT_CMD_QUEUE_EN adds a 2-entry command FIFO ahead of the sequencer.
module pit_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pit_bus_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_RESP
    } state_e;

    typedef struct packed {
        logic        op;
        logic [1:0]  chan;
        logic [1:0]  rw;
        logic [2:0]  mode;
        logic [15:0] count;
    } cmd_t;

    state_e      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic [15:0] rdat_q, rdat_d;
    logic [15:0] rsp_data_q, rsp_data_d;

    cmd_t in_cmd, head;
    logic head_vld, pop;

    assign in_cmd = {bus.cmd_op, bus.cmd_chan, bus.cmd_rw, bus.cmd_mode, bus.cmd_count};
    assign pop    = (state_q == S_IDLE) && head_vld;

`ifdef PIT_CMD_QUEUE_EN
    cmd_t       fifo_q [2];
    logic       wptr_q, rptr_q;
    logic [1:0] lvl_q;
    logic       push;

    assign bus.cmd_ready = (lvl_q != 2'd2);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head_vld      = (lvl_q != 2'd0);
    assign head          = fifo_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            lvl_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= in_cmd;
                wptr_q         <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            lvl_q <= lvl_q + {1'b0, push} - {1'b0, pop};
        end
    end
`else
    assign bus.cmd_ready = (state_q == S_IDLE);
    assign head_vld      = bus.cmd_valid;
    assign head          = in_cmd;
`endif

    // Cycle 0 is always the control/latch word write to a1a0=11; later cycles
    // touch the counter register, MSB second when both bytes are moved.
    logic       illegal, last_cyc, is_wr_cyc, hi_byte;
    logic [7:0] wr_byte;

    assign illegal   = (head.chan == 2'd3) || (head.rw == 2'b00);
    assign last_cyc  = (idx_q == ((cmd_q.rw == 2'b11) ? 2'd2 : 2'd1));
    assign is_wr_cyc = (idx_q == 2'd0) || !cmd_q.op;
    assign hi_byte   = (cmd_q.rw == 2'b10) || (idx_q == 2'd2);

    always_comb begin
        wr_byte = 8'h00;
        if (idx_q == 2'd0)
            wr_byte = cmd_q.op ? {cmd_q.chan, 6'b000000}
                               : {cmd_q.chan, cmd_q.rw, cmd_q.mode, 1'b0};
        else
            wr_byte = hi_byte ? cmd_q.count[15:8] : cmd_q.count[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            cnt_q      <= 4'd0;
            idx_q      <= 2'd0;
            err_q      <= 1'b0;
            rdat_q     <= 16'h0000;
            rsp_data_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            rdat_q     <= rdat_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        rdat_d     = rdat_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (head_vld) begin
                    cmd_d  = head;
                    cnt_d  = 4'd0;
                    idx_d  = 2'd0;
                    rdat_d = 16'h0000;
                    err_d  = illegal;
                    // Illegal commands idle the bus for one GAP clock, so the
                    // error strobe lands in the second clock after accept.
                    state_d = illegal ? S_GAP : S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'(SETUP_CYC - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 4'(STROBE_CYC - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = S_HOLD;
                    if (!is_wr_cyc) begin
                        if (hi_byte) rdat_d[15:8] = bus.d_in;
                        else         rdat_d[7:0]  = bus.d_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'(HOLD_CYC - 1)) begin
                    cnt_d = 4'd0;
                    if (last_cyc) begin
                        state_d    = S_RESP;
                        rsp_data_d = rdat_q;
                    end else begin
                        state_d = S_GAP;
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_GAP: begin
                if (err_q) begin
                    state_d    = S_RESP;
                    rsp_data_d = 16'h0000;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus pins decode straight from registered state so reset releases them at once.
    logic active;
    assign active         = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    assign bus.cs_n       = !active;
    assign bus.wr_n       = !((state_q == S_STROBE) && is_wr_cyc);
    assign bus.rd_n       = !((state_q == S_STROBE) && !is_wr_cyc);
    assign {bus.a1, bus.a0} = active ? ((idx_q == 2'd0) ? 2'b11 : cmd_q.chan) : 2'b00;
    assign bus.d_oe       = active && is_wr_cyc;
    assign bus.d_out      = bus.d_oe ? wr_byte : 8'h00;
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_err    = (state_q == S_RESP) && err_q;
    assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_pit_bus_master.sv
// Bench for pit_bus_master: vector table, random commands against a transaction
// model, slow-timing instance trace, and reset during a write strobe.
module tb_pit_bus_master;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pit_bus_master_if bif ();
    pit_bus_master_if bif2 ();

    pit_bus_master dut (.clk(clk), .rst_n(rst_n), .bus(bif));
    pit_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bif2));

`ifdef PIT_CMD_QUEUE_EN
    localparam int LAT_ADJ = 1;
`else
    localparam int LAT_ADJ = 0;
`endif

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One observed or expected 8253 bus cycle.
    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        int         cs_len;
        int         st_len;
    } beat_t;

    beat_t mon_q[$];
    beat_t exp_q[$];
    int         cs_len = 0, st_len = 0;
    logic       cur_wr;
    logic [1:0] cur_a;
    logic [7:0] cur_d;
    logic       prev_rd_low = 1'b0;
    int         rd_total = 0, rd_base = 0;
    logic [7:0] rd_b0 = 8'h00, rd_b1 = 8'h00;

    // 8253 read model: first read of a command returns rd_b0, later ones rd_b1.
    assign bif.d_in = (rd_total == rd_base) ? rd_b0 : rd_b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            cs_len = 0;
            st_len = 0;
            prev_rd_low = 1'b0;
        end else begin
            chk("rd_wr_overlap", {63'd0, !bif.rd_n && !bif.wr_n}, 64'd0);
            chk("doe_during_rd", {63'd0, bif.d_oe && !bif.rd_n}, 64'd0);
            if (prev_rd_low && bif.rd_n) rd_total++;
            prev_rd_low = !bif.rd_n;
            if (!bif.cs_n) begin
                cs_len++;
                if (!bif.wr_n || !bif.rd_n) begin
                    st_len++;
                    cur_wr = !bif.wr_n;
                    cur_a  = {bif.a1, bif.a0};
                    cur_d  = bif.d_out;
                end
            end else if (cs_len > 0) begin
                mon_q.push_back('{cur_wr, cur_a, cur_d, cs_len, st_len});
                cs_len = 0;
                st_len = 0;
            end
        end
    end

    // Transaction model: bus cycles, response data and latency from command fields.
    task automatic build_exp(input logic op, input logic [1:0] chan, input logic [1:0] rw,
                             input logic [2:0] mode, input logic [15:0] cnt);
        int nb;
        logic hi;
        exp_q.delete();
        if (chan == 2'd3 || rw == 2'b00) return;
        exp_q.push_back('{1'b1, 2'd3, op ? {chan, 6'd0} : {chan, rw, mode, 1'b0}, 4, 2});
        nb = (rw == 2'b11) ? 2 : 1;
        for (int i = 0; i < nb; i++) begin
            hi = (rw == 2'b10) || (i == 1);
            exp_q.push_back('{!op, chan, op ? 8'h00 : (hi ? cnt[15:8] : cnt[7:0]), 4, 2});
        end
    endtask

    function automatic int model_lat(input logic [1:0] chan, input logic [1:0] rw);
        if (chan == 2'd3 || rw == 2'b00) return 2;
        return 5 * ((rw == 2'b11) ? 3 : 2);
    endfunction

    function automatic logic [15:0] model_data(input logic op, input logic [1:0] rw,
                                               input logic [7:0] b0, input logic [7:0] b1);
        if (!op) return 16'h0000;
        case (rw)
            2'b01:   return {8'h00, b0};
            2'b10:   return {b0, 8'h00};
            default: return {b1, b0};
        endcase
    endfunction

    task automatic run_cmd(input logic op, input logic [1:0] chan, input logic [1:0] rw,
                           input logic [2:0] mode, input logic [15:0] cnt,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input int exp_lat, input logic exp_err, input logic [15:0] exp_data);
        int lat = 0;
        logic got_err;
        logic [15:0] got_data;
        build_exp(op, chan, rw, mode, cnt);
        mon_q.delete();
        rd_base = rd_total;
        rd_b0 = b0;
        rd_b1 = b1;
        @(negedge clk);
        bif.cmd_op = op; bif.cmd_chan = chan; bif.cmd_rw = rw;
        bif.cmd_mode = mode; bif.cmd_count = cnt; bif.cmd_valid = 1'b1;
        for (int w = 0; w < 50 && !bif.cmd_ready; w++) @(negedge clk);
        if (!bif.cmd_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            bif.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bif.cmd_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
`ifndef PIT_CMD_QUEUE_EN
            if (k == 1) chk("busy_not_ready", {63'd0, bif.cmd_ready}, 64'd0);
`endif
            if (bif.rsp_valid) begin
                lat = k;
                got_err = bif.rsp_err;
                got_data = bif.rsp_data;
                break;
            end
        end
        if (lat == 0) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        chk("rsp_latency", lat, exp_lat + LAT_ADJ);
        chk("rsp_err", {63'd0, got_err}, {63'd0, exp_err});
        if (!exp_err) chk("rsp_data", {48'd0, got_data}, {48'd0, exp_data});
        @(negedge clk);
        chk("rsp_one_clock", {63'd0, bif.rsp_valid}, 64'd0);
        chk("beat_count", mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            chk("beat_wr", {63'd0, mon_q[i].wr}, {63'd0, exp_q[i].wr});
            chk("beat_addr", {62'd0, mon_q[i].addr}, {62'd0, exp_q[i].addr});
            if (exp_q[i].wr) chk("beat_data", {56'd0, mon_q[i].data}, {56'd0, exp_q[i].data});
            chk("beat_cs_len", mon_q[i].cs_len, exp_q[i].cs_len);
            chk("beat_strobe_len", mon_q[i].st_len, exp_q[i].st_len);
        end
    endtask

    typedef struct {
        logic        op;
        logic [1:0]  chan;
        logic [1:0]  rw;
        logic [2:0]  mode;
        logic [15:0] cnt;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          lat;
        logic        err;
        logic [15:0] data;
        logic [7:0]  ctl;
    } vec_t;

    vec_t tv[8];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] act_cs, act_wr, act_rsp, exp_cs, exp_wr, exp_rsp;
        logic        seen;
        logic        op;
        logic [1:0]  chan, rw;
        logic [2:0]  mode;
        logic [15:0] cnt;
        logic [7:0]  b0, b1;
        int          c;

        tv[0] = '{1'b0, 2'd0, 2'b11, 3'd3, 16'h1234, 8'h00, 8'h00, 15, 1'b0, 16'h0000, 8'h36};
        tv[1] = '{1'b1, 2'd2, 2'b11, 3'd0, 16'h0000, 8'hCD, 8'hAB, 15, 1'b0, 16'hABCD, 8'h80};
        tv[2] = '{1'b1, 2'd1, 2'b10, 3'd0, 16'h0000, 8'h5A, 8'h00, 10, 1'b0, 16'h5A00, 8'h40};
        tv[3] = '{1'b0, 2'd3, 2'b11, 3'd3, 16'h1234, 8'h00, 8'h00,  2, 1'b1, 16'h0000, 8'h00};
        tv[4] = '{1'b1, 2'd1, 2'b00, 3'd0, 16'h0000, 8'h00, 8'h00,  2, 1'b1, 16'h0000, 8'h00};
        tv[5] = '{1'b0, 2'd2, 2'b01, 3'd7, 16'h00FF, 8'h00, 8'h00, 10, 1'b0, 16'h0000, 8'h9E};
        tv[6] = '{1'b0, 2'd1, 2'b10, 3'd5, 16'hABCD, 8'h00, 8'h00, 10, 1'b0, 16'h0000, 8'h6A};
        tv[7] = '{1'b1, 2'd0, 2'b01, 3'd0, 16'h0000, 8'h3C, 8'h99, 10, 1'b0, 16'h003C, 8'h00};

        bif.cmd_valid = 1'b0; bif.cmd_op = 1'b0; bif.cmd_chan = 2'd0; bif.cmd_rw = 2'd0;
        bif.cmd_mode = 3'd0; bif.cmd_count = 16'h0;
        bif2.cmd_valid = 1'b0; bif2.cmd_op = 1'b0; bif2.cmd_chan = 2'd0; bif2.cmd_rw = 2'd0;
        bif2.cmd_mode = 3'd0; bif2.cmd_count = 16'h0; bif2.d_in = 8'h00;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {63'd0, bif.cs_n}, 64'd1);
        chk("rst_rd_n", {63'd0, bif.rd_n}, 64'd1);
        chk("rst_wr_n", {63'd0, bif.wr_n}, 64'd1);
        chk("rst_addr", {62'd0, bif.a1, bif.a0}, 64'd0);
        chk("rst_d_out", {56'd0, bif.d_out}, 64'd0);
        chk("rst_d_oe", {63'd0, bif.d_oe}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bif.rsp_valid}, 64'd0);
        chk("rst_rsp_err", {63'd0, bif.rsp_err}, 64'd0);
        chk("rst_rsp_data", {48'd0, bif.rsp_data}, 64'd0);
        chk("rst_cmd_ready", {63'd0, bif.cmd_ready}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tv[i].op, tv[i].chan, tv[i].rw, tv[i].mode, tv[i].cnt,
                    tv[i].b0, tv[i].b1, tv[i].lat, tv[i].err, tv[i].data);
            if (!tv[i].err && mon_q.size() > 0)
                chk("ctl_word", {56'd0, mon_q[0].data}, {56'd0, tv[i].ctl});
        end

        // Slow timing instance: program chan1 rw=01 -> two 9-clock cycles, one GAP.
        @(negedge clk);
        bif2.cmd_op = 1'b0; bif2.cmd_chan = 2'd1; bif2.cmd_rw = 2'b01;
        bif2.cmd_mode = 3'd2; bif2.cmd_count = 16'h0077; bif2.cmd_valid = 1'b1;
        for (int w = 0; w < 50 && !bif2.cmd_ready; w++) @(negedge clk);
        chk("slow_accept", {63'd0, bif2.cmd_ready}, 64'd1);
        @(posedge clk);
        #1 bif2.cmd_valid = 1'b0;
        act_cs = '0; act_wr = '0; act_rsp = '0; exp_cs = '0; exp_wr = '0; exp_rsp = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            act_cs[k]  = !bif2.cs_n;
            act_wr[k]  = !bif2.wr_n;
            act_rsp[k] = bif2.rsp_valid;
            c = k - 1 - LAT_ADJ;
            if (c >= 0 && c < 20 && (c % 10) < 9) exp_cs[k] = 1'b1;
            if (c >= 0 && c < 20 && (c % 10) >= 3 && (c % 10) <= 6) exp_wr[k] = 1'b1;
            if (c == 19) exp_rsp[k] = 1'b1;
        end
        chk("slow_cs_trace", act_cs, exp_cs);
        chk("slow_wr_trace", act_wr, exp_wr);
        chk("slow_rsp_trace", act_rsp, exp_rsp);

        for (int i = 0; i < 40; i++) begin
            op   = 1'($urandom_range(0, 1));
            chan = 2'($urandom_range(0, 3));
            rw   = 2'($urandom_range(0, 3));
            mode = 3'($urandom_range(0, 7));
            cnt  = 16'($urandom);
            b0   = 8'($urandom);
            b1   = 8'($urandom);
            run_cmd(op, chan, rw, mode, cnt, b0, b1, model_lat(chan, rw),
                    (chan == 2'd3) || (rw == 2'b00), model_data(op, rw, b0, b1));
        end

        // Reset in the middle of a write strobe aborts the cycle, no response.
        @(negedge clk);
        bif.cmd_op = 1'b0; bif.cmd_chan = 2'd0; bif.cmd_rw = 2'b11;
        bif.cmd_mode = 3'd2; bif.cmd_count = 16'h5555; bif.cmd_valid = 1'b1;
        for (int w = 0; w < 50 && !bif.cmd_ready; w++) @(negedge clk);
        @(posedge clk);
        #1 bif.cmd_valid = 1'b0;
        for (int w = 0; w < 20 && bif.wr_n; w++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_reach_strobe", {63'd0, bif.wr_n}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_n", {63'd0, bif.wr_n}, 64'd1);
        chk("rst_mid_cs_n", {63'd0, bif.cs_n}, 64'd1);
        chk("rst_mid_d_oe", {63'd0, bif.d_oe}, 64'd0);
        chk("rst_mid_rsp_data", {48'd0, bif.rsp_data}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            seen = seen | bif.rsp_valid | !bif.cs_n;
        end
        chk("no_activity_after_reset", {63'd0, seen}, 64'd0);
        chk("ready_after_reset", {63'd0, bif.cmd_ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pit_bus_master.md
Name: pit_bus_master

Overview:
- Synchronous host-side sequencer that programs and reads the 8253 interval timer over its 8-bit bus.
- Accepts high-level commands (program channel, latch-and-read channel) on a valid/ready interface.
- Expands each command into timed 8253 bus cycles on cs_n/rd_n/wr_n/a1/a0/d; returns read data and status on a one-cycle response strobe.
- Sits between the PC system controller and the 8253; the inout data bus is resolved at top level from d_out/d_oe/d_in.

Parameters:
SETUP_CYC, 1, clocks with cs_n/address (and write data) stable before strobe; legal range 1..15
STROBE_CYC, 2, clocks rd_n or wr_n held low; legal range 1..15
HOLD_CYC, 1, clocks cs_n/address/data held after strobe rises; legal range 1..15

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted on clk edge when cmd_valid & cmd_ready
cmd_op  in  1  0 = program channel, 1 = latch-and-read channel
cmd_chan  in  2  counter select 0..2; 3 is illegal
cmd_rw  in  2  01 LSB only, 10 MSB only, 11 LSB then MSB; 00 illegal
cmd_mode  in  3  8253 mode 0..5 (program only)
cmd_count  in  16  initial count (program only)
rsp_valid  out  1  one-clock response strobe
rsp_err  out  1  qualifies rsp_valid; illegal command, no bus activity
rsp_data  out  16  read result, valid with rsp_valid
cs_n, rd_n, wr_n  out  1 each  8253 bus strobes, active low
a1, a0  out  1 each  8253 register address
d_out  out  8  write data
d_oe  out  1  drive d_out onto bus
d_in  in  8  bus read data

Behaviour:
- Reset (async, immediate): cs_n=rd_n=wr_n=1, a1=a0=0, d_out=0, d_oe=0, rsp_valid=0, rsp_err=0, rsp_data=0, cmd_ready=1. Reset mid-cycle aborts the cycle: strobes go high combinationally with reset, and no response is issued.
- States: IDLE, SETUP, STROBE, HOLD, GAP, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch all cmd fields.
  - If cmd_chan==3 or cmd_rw==00, go to RESP with rsp_err=1. No bus cycle occurs.
- SETUP: cs_n=0; a1/a0 set; for writes d_oe=1 with d_out valid. Lasts SETUP_CYC clocks.
- STROBE: wr_n=0 (write) or rd_n=0 (read) for STROBE_CYC clocks. d_in is sampled on the last STROBE clock.
- HOLD: strobes high; cs_n, address, d_out and d_oe unchanged for HOLD_CYC clocks. The 8253 captures on the rising wr_n, so data must remain held here.
- After HOLD:
  - If more bus cycles remain: GAP for 1 clock with cs_n=1 and d_oe=0, then SETUP.
  - Else: RESP.
- RESP: cs_n=1; rsp_valid=1 for exactly 1 clock; then IDLE. rsp_data holds its value until the next RESP.
- Program sequence:
  1. Write control word to a1a0=11: {cmd_chan, cmd_rw, cmd_mode, 1'b0} (binary counting).
  2. Write to a1a0=cmd_chan: rw=01 sends count[7:0]; rw=10 sends count[15:8]; rw=11 sends count[7:0] then count[15:8].
  - rsp_data=0 for program commands.
- Read sequence:
  1. Write latch word {cmd_chan, 2'b00, 4'b0000} to a1a0=11.
  2. Read a1a0=cmd_chan: rw=01 returns {8'h00, lsb}; rw=10 returns {msb, 8'h00}; rw=11 reads lsb then msb and returns {msb, lsb}.
- cmd_mode of 6 or 7 is passed through unchanged and is not flagged.
- Latency (defaults), counted as clocks after the accept edge: RESP occurs in clock 4N+(N-1)+1, where N = number of bus cycles. Program rw=11 → clock 15; read rw=01 → clock 10.
- rd_n and wr_n are never low together. d_oe is never 1 while rd_n=0.

Optional Feature:
PIT_CMD_QUEUE_EN
- Defined: a 2-entry command FIFO sits in front of the sequencer.
  - cmd_ready = !fifo_full.
  - Commands are accepted during bus activity.
  - The sequencer leaves RESP and pops the next entry in the following IDLE clock (IDLE always lasts ≥1 clock).
  - Reset empties the FIFO.
  - Commands execute in order; illegal commands still produce an in-order error response.
- Undefined: no FIFO; cmd_ready=1 only in IDLE.

Test Plan:
- Reset asserted during STROBE of a write → wr_n=1, cs_n=1, d_oe=0 immediately; no rsp_valid after release.
- Program chan0, mode 3, rw=11, count 16'h1234, defaults → bus writes: 8'h36 to a=3, 8'h34 to a=0, 8'h12 to a=0. Each write has wr_n low 2 clocks; rsp_valid in clock 15 with rsp_err=0.
- Read chan2, rw=11, d_in=8'hCD on 1st read and 8'hAB on 2nd → latch word 8'h80 to a=2'b11; two reads at a=2; rsp_data=16'hABCD.
- Read chan1, rw=10, d_in=8'h5A → rsp_data=16'h5A00; rsp_valid in clock 10.
- cmd_chan=3 or cmd_rw=00 → cs_n stays 1; rsp_valid=1 with rsp_err=1 in the 2nd clock after accept.
- SETUP_CYC=3, STROBE_CYC=4, HOLD_CYC=2, program rw=01 → cs_n low exactly 9 clocks per cycle, with wr_n low for clocks 4-7 of that window; one GAP clock between cycles.
